tpu_tiled_core: RTL and testbench
=================================

// Module: tpu_tiled_core
// PURPOSE
//  Parametrised output-stationary systolic matmul engine: computes C[m x n] = A[m x k] * B[k x n].
//  Matrices larger than the ARRAY_DIM x ARRAY_DIM array are handled by tiling.
//  Reads A/B from two global buffers and writes C to the output global buffer.
//  Sits between the top-level start/done handshake and the three buffers; successor to the fixed 4x4 engine.
// PARAMETERS
//  ARRAY_DIM  4  PE rows = PE cols (D); tile edge
//  DATA_W     8  unsigned operand width
//  ACC_W      8  accumulator / result element width
//  ADDR_W     8  global-buffer index width
//  DIM_W      4  width of m/n/k
// PORTS
//  clk           in   1              clock, rising edge
//  rst           in   1              asynchronous reset, active-high
//  start         in   1              start request, sampled in IDLE only
//  m, n, k       in   DIM_W each     dimensions, sampled with start
//  busy          out  1              high from start accept until DONE
//  done          out  1              high in DONE; cleared by the next accepted start
//  a_index       out  ADDR_W         A buffer read index
//  a_rdata       in   D*DATA_W       A word (D row elems of one k col, row0 in MSBs); valid 1 cycle after index
//  b_index       out  ADDR_W         B buffer read index
//  b_rdata       in   D*DATA_W       B word (D col elems of one k row, col0 in MSBs); valid 1 cycle after index
//  o_wr_en       out  1              C write strobe
//  o_index       out  ADDR_W         C write index
//  o_wdata       out  D*ACC_W        C row segment, col0 in MSBs
// BEHAVIOUR
//  Reset values: busy=0, done=0, o_wr_en=0, all indices=0, o_wdata=0, FSM=IDLE, all accumulators=0.
//  Tiles: TM=ceil(m/D), TN=ceil(n/D); row-tile tm outer loop, col-tile tn inner loop.
//  A address = tm*k+kk; B address = tn*k+kk. Lanes beyond m or n are fed 0.
//  FSM: IDLE -(start)-> LOAD -> FEED -> DRAIN -> WRITE -> (more tiles ? LOAD : DONE).
//   - start while not IDLE is ignored.
//   - m==0 | n==0 | k==0: IDLE->DONE in 1 cycle; no writes issued.
//   - LOAD: issue kk=0..k-1 on a_index/b_index, one per cycle.
//     Capture a_rdata/b_rdata one cycle later into skew buffers (depth k<=15 words each); k+1 cycles.
//     Accumulators clear on LOAD entry.
//   - FEED: row r / column c operand delayed r / c cycles (skew); k+2D-2 cycles.
//     PE(r,c) accumulates a*b each valid cycle. Products are truncated to ACC_W.
//     Accumulation wraps mod 2^ACC_W.
//   - DRAIN: 1 cycle for the final MAC to settle.
//   - WRITE: one word per valid row r < min(D, m-tm*D), o_wr_en=1 each cycle.
//     o_index = tn*m + tm*D + r; o_wdata = {acc[r][0..D-1]}, cols >= n-tn*D forced 0.
//   - DONE: busy=0, done=1; start there -> LOAD with new dims (done drops same edge).
//  Indices never exceed 2^ADDR_W-1 for m,n,k <= 15 with D >= 2 (checked by assertion).
//  Reset mid-operation: immediate return to IDLE.
//   No o_wr_en in the reset cycle or the cycle after; partial results discarded.
// STRUCTURE
//  Shared package tpu_pkg: FSM state encoding, D/DATA_W/ACC_W defaults, word-lane slice macro.
//  Sub-module tpu_pe_acc: one output-stationary PE.
//   - a/b in, registered a/b out to right/down neighbours, clr, en, ACC_W accumulator.
//   - Instantiated D*D times via generate.
//  Top holds FSM, tile/kk/row counters, skew registers, output mux.
// TESTING
//  T1 D=4, m=n=k=4, A=I, B=1..16: 4 writes idx0..3; word0 = {8'd1,8'd2,8'd3,8'd4}; done after 1 tile.
//  T2 m=n=k=2: 2 writes idx0,1; upper 2 lanes of each word = 0; nothing written at idx>=2.
//  T3 m=n=k=9 (3x3 tiles), random A/B:
//     - 81 results match the mod-256 golden model; 27 writes.
//     - indices follow tn*9+row; each index written exactly once.
//  T4 overflow: all A=B=255, k=4 -> every element = (4*255*255) mod 256 = 4.
//  T5 k=0, m=n=3: done within 2 cycles of start, o_wr_en never asserted.
//     A start pulse during busy in another run is ignored.
//  T6 assert rst during FEED of tile 2:
//     - busy=done=o_wr_en=0 next cycle.
//     - Restart with m=n=k=4 gives T1 results exactly.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and defaults for the tiled systolic matmul engine.
package tpu_pkg;

  localparam int D_DEF      = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Bit offset of lane idx in a word of 'lanes' elements, lane 0 in the MSBs.
  function automatic int lane_lsb(input int idx, input int lanes, input int w);
    return (lanes - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/tpu_pe_acc.sv
// Output-stationary PE: accumulates a*b mod 2^ACC_W, forwards operands right/down.
// One-cycle operand forwarding; no backpressure, clr flushes accumulator and pipeline.
module tpu_pe_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ACC_W-1:0]    acc_q;

  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (en) acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/tpu_tiled_core.sv
// Tiled output-stationary systolic matmul C = A*B over a D x D PE array.
// Per tile: LOAD k+1, FEED k+2D-2, DRAIN 1, WRITE one cycle per valid row; no backpressure.
module tpu_tiled_core
  import tpu_pkg::*;
#(
  parameter int ARRAY_DIM = D_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ADDR_W    = 8,
  parameter int DIM_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DIM_W-1:0]              m,
  input  logic [DIM_W-1:0]              n,
  input  logic [DIM_W-1:0]              k,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             a_index,
  input  logic [ARRAY_DIM*DATA_W-1:0]   a_rdata,
  output logic [ADDR_W-1:0]             b_index,
  input  logic [ARRAY_DIM*DATA_W-1:0]   b_rdata,
  output logic                          o_wr_en,
  output logic [ADDR_W-1:0]             o_index,
  output logic [ARRAY_DIM*ACC_W-1:0]    o_wdata
);

  localparam int D  = ARRAY_DIM;
  localparam int KD = 2**DIM_W;
  localparam logic [ADDR_W-1:0] DA        = ADDR_W'(D);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FEED_TAIL = ADDR_W'(2*D-3);

  state_t                state_q;
  logic                  busy_q, done_q, o_wr_en_q;
  logic [DIM_W-1:0]      m_q, n_q, k_q, tm_q, tn_q;
  logic [ADDR_W-1:0]     cnt_q, wr_q, a_index_q, b_index_q, o_index_q;
  logic [D*ACC_W-1:0]    o_wdata_q;
  logic [D*DATA_W-1:0]   abuf_q [KD];
  logic [D*DATA_W-1:0]   bbuf_q [KD];

  logic [ADDR_W-1:0]     mw, nw, kw, tmw, tnw, rem_m, rem_n, rows_c, cols_c, out_base, row_sel;
  logic                  more_tn, more_tm, dims_zero, idx_ok, pe_clr, pe_en;
  logic [DIM_W-1:0]      tm_nx, tn_nx, wptr;
  logic [D*DATA_W-1:0]   a_cap, b_cap;
  logic [D*ACC_W-1:0]    row_word_d;
  logic [DATA_W-1:0]     a_edge [D];
  logic [DATA_W-1:0]     b_edge [D];
  logic [DATA_W-1:0]     a_in   [D][D];
  logic [DATA_W-1:0]     b_in   [D][D];
  logic [DATA_W-1:0]     a_pipe [D][D];
  logic [DATA_W-1:0]     b_pipe [D][D];
  logic [ACC_W-1:0]      acc    [D][D];

  assign mw  = ADDR_W'(m_q);
  assign nw  = ADDR_W'(n_q);
  assign kw  = ADDR_W'(k_q);
  assign tmw = ADDR_W'(tm_q);
  assign tnw = ADDR_W'(tn_q);

  always_comb begin
    rem_m     = mw - tmw * DA;
    rem_n     = nw - tnw * DA;
    rows_c    = (rem_m > DA) ? DA : rem_m;
    cols_c    = (rem_n > DA) ? DA : rem_n;
    more_tn   = ((tnw + ONE) * DA) < nw;
    more_tm   = ((tmw + ONE) * DA) < mw;
    tm_nx     = more_tn ? tm_q : tm_q + 1'b1;
    tn_nx     = more_tn ? tn_q + 1'b1 : '0;
    dims_zero = (m == '0) || (n == '0) || (k == '0);
    out_base  = tnw * mw + tmw * DA;
    row_sel   = (state_q == ST_WRITE) ? wr_q : '0;
    wptr      = DIM_W'(cnt_q - ONE);
    pe_clr    = (state_q == ST_LOAD);
    pe_en     = (state_q == ST_FEED);
    idx_ok    = ((int'(tm_q) + 1) * int'(k_q) <= 2**ADDR_W) &&
                ((int'(tn_q) + 1) * int'(k_q) <= 2**ADDR_W) &&
                ((int'(tn_q) + 1) * int'(m_q) <= 2**ADDR_W);
  end

  // Lanes past the matrix edge are zeroed at capture so the array never sees them.
  always_comb begin
    a_cap = '0;
    b_cap = '0;
    for (int r = 0; r < D; r++) begin
      if (ADDR_W'(r) < rows_c)
        a_cap[lane_lsb(r, D, DATA_W) +: DATA_W] = a_rdata[lane_lsb(r, D, DATA_W) +: DATA_W];
      if (ADDR_W'(r) < cols_c)
        b_cap[lane_lsb(r, D, DATA_W) +: DATA_W] = b_rdata[lane_lsb(r, D, DATA_W) +: DATA_W];
    end
  end

  // Row r / column c enters the array r / c cycles late so matching kk meet in PE(r,c).
  always_comb begin
    for (int r = 0; r < D; r++) begin
      a_edge[r] = '0;
      b_edge[r] = '0;
      if (state_q == ST_FEED && cnt_q >= ADDR_W'(r) && (cnt_q - ADDR_W'(r)) < kw) begin
        a_edge[r] = abuf_q[DIM_W'(cnt_q - ADDR_W'(r))][lane_lsb(r, D, DATA_W) +: DATA_W];
        b_edge[r] = bbuf_q[DIM_W'(cnt_q - ADDR_W'(r))][lane_lsb(r, D, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    row_word_d = '0;
    for (int rr = 0; rr < D; rr++) begin
      if (ADDR_W'(rr) == row_sel) begin
        for (int c = 0; c < D; c++) begin
          if (ADDR_W'(c) < cols_c) row_word_d[lane_lsb(c, D, ACC_W) +: ACC_W] = acc[rr][c];
        end
      end
    end
  end

  for (genvar r = 0; r < D; r++) begin : g_row
    for (genvar c = 0; c < D; c++) begin : g_col
      if (c == 0) begin : g_al
        assign a_in[r][c] = a_edge[r];
      end else begin : g_ar
        assign a_in[r][c] = a_pipe[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign b_in[r][c] = b_edge[c];
      end else begin : g_bd
        assign b_in[r][c] = b_pipe[r-1][c];
      end
      tpu_pe_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (pe_clr),
        .en    (pe_en),
        .a_i   (a_in[r][c]),
        .b_i   (b_in[r][c]),
        .a_o   (a_pipe[r][c]),
        .b_o   (b_pipe[r][c]),
        .acc_o (acc[r][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && cnt_q != '0) begin
      abuf_q[wptr] <= a_cap;
      bbuf_q[wptr] <= b_cap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      tm_q      <= '0;
      tn_q      <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      a_index_q <= '0;
      b_index_q <= '0;
      o_wr_en_q <= 1'b0;
      o_index_q <= '0;
      o_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            m_q       <= m;
            n_q       <= n;
            k_q       <= k;
            tm_q      <= '0;
            tn_q      <= '0;
            cnt_q     <= '0;
            a_index_q <= '0;
            b_index_q <= '0;
            if (dims_zero) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (cnt_q == kw) begin
            state_q <= ST_FEED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
            if (cnt_q + ONE < kw) begin
              a_index_q <= a_index_q + ONE;
              b_index_q <= b_index_q + ONE;
            end
          end
        end
        ST_FEED: begin
          if (cnt_q == kw + FEED_TAIL) state_q <= ST_DRAIN;
          else                         cnt_q   <= cnt_q + ONE;
        end
        ST_DRAIN: begin
          state_q   <= ST_WRITE;
          wr_q      <= ONE;
          o_wr_en_q <= 1'b1;
          o_index_q <= out_base;
          o_wdata_q <= row_word_d;
        end
        ST_WRITE: begin
          if (wr_q < rows_c) begin
            wr_q      <= wr_q + ONE;
            o_index_q <= out_base + wr_q;
            o_wdata_q <= row_word_d;
          end else begin
            o_wr_en_q <= 1'b0;
            o_wdata_q <= '0;
            if (more_tn || more_tm) begin
              state_q   <= ST_LOAD;
              tm_q      <= tm_nx;
              tn_q      <= tn_nx;
              cnt_q     <= '0;
              a_index_q <= ADDR_W'(tm_nx) * kw;
              b_index_q <= ADDR_W'(tn_nx) * kw;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) idx_ok);

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_index = a_index_q;
  assign b_index = b_index_q;
  assign o_wr_en = o_wr_en_q;
  assign o_index = o_index_q;
  assign o_wdata = o_wdata_q;

endmodule

// File: tb/tb_tpu_tiled_core.sv
// Scoreboard bench for tpu_tiled_core: golden mod-256 matmul, expected writes queued per run.
`timescale 1ns/1ps
module tb_tpu_tiled_core;

  localparam int D  = 4;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct {
    logic [AW-1:0]   idx;
    logic [D*8-1:0]  dat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [3:0]      m = '0, n = '0, k = '0;
  logic            busy, done, o_wr_en;
  logic [AW-1:0]   a_index, b_index, o_index;
  logic [D*DW-1:0] a_rdata, b_rdata;
  logic [D*8-1:0]  o_wdata;

  logic [D*DW-1:0] amem [256];
  logic [D*DW-1:0] bmem [256];
  int              amat [16][16];
  int              bmat [16][16];
  exp_t            sb [$];

  int              n_vec = 0;
  int              n_bad = 0;
  int              wr_cnt = 0;
  bit              first_seen = 1'b0;
  logic [D*8-1:0]  first_wd = '0;
  string           cur_tag = "rst";

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rdata <= amem[a_index];
    b_rdata <= bmem[b_index];
  end

  tpu_tiled_core dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .m       (m),
    .n       (n),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .a_index (a_index),
    .a_rdata (a_rdata),
    .b_index (b_index),
    .b_rdata (b_rdata),
    .o_wr_en (o_wr_en),
    .o_index (o_index),
    .o_wdata (o_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_wr_en === 1'b1) begin
        wr_cnt++;
        if (!first_seen) begin
          first_wd   = o_wdata;
          first_seen = 1'b1;
        end
        if (sb.size() == 0) begin
          chk({cur_tag, "_unexp_wr"}, 64'(o_wr_en), 64'd0);
        end else begin
          e = sb.pop_front();
          chk({cur_tag, "_wr_idx"}, 64'(o_index), 64'(e.idx));
          chk({cur_tag, "_wr_dat"}, 64'(o_wdata), 64'(e.dat));
        end
      end
    end
  endtask

  // Loads the buffers (with garbage outside the matrices) and queues the expected writes.
  task automatic prep(input string tag, input int mm, input int nn, input int kd);
    exp_t e;
    int   tmn, tnn, row, col, s;
    cur_tag    = tag;
    wr_cnt     = 0;
    first_seen = 1'b0;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      amem[i] = $urandom;
      bmem[i] = $urandom;
    end
    tmn = (mm + D - 1) / D;
    tnn = (nn + D - 1) / D;
    for (int t = 0; t < tmn; t++)
      for (int x = 0; x < kd; x++)
        for (int r = 0; r < D; r++) begin
          row = t * D + r;
          amem[t*kd+x][(D-1-r)*DW +: DW] = (row < mm) ? 8'(amat[row][x]) : 8'($urandom);
        end
    for (int t = 0; t < tnn; t++)
      for (int x = 0; x < kd; x++)
        for (int c = 0; c < D; c++) begin
          col = t * D + c;
          bmem[t*kd+x][(D-1-c)*DW +: DW] = (col < nn) ? 8'(bmat[x][col]) : 8'($urandom);
        end
    if (mm != 0 && nn != 0 && kd != 0) begin
      for (int tm = 0; tm < tmn; tm++)
        for (int tn = 0; tn < tnn; tn++)
          for (int r = 0; r < D; r++) begin
            row = tm * D + r;
            if (row < mm) begin
              e.idx = AW'(tn * mm + row);
              e.dat = '0;
              for (int c = 0; c < D; c++) begin
                col = tn * D + c;
                if (col < nn) begin
                  s = 0;
                  for (int x = 0; x < kd; x++) s += amat[row][x] * bmat[x][col];
                  e.dat[(D-1-c)*8 +: 8] = 8'(s & 255);
                end
              end
              sb.push_back(e);
            end
          end
    end
  endtask

  task automatic kick(input int mm, input int nn, input int kd);
    @(negedge clk);
    m = 4'(mm);
    n = 4'(nn);
    k = 4'(kd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int mm, input int nn, input int kd, input bit ign);
    int  cyc;
    int  exp_wr;
    bit  zero;
    zero = (mm == 0 || nn == 0 || kd == 0);
    prep(tag, mm, nn, kd);
    exp_wr = sb.size();
    kick(mm, nn, kd);
    cyc = 1;
    if (!zero) begin
      chk({tag, "_busy_on"}, 64'(busy), 64'd1);
      chk({tag, "_done_clr"}, 64'(done), 64'd0);
    end
    while (done !== 1'b1 && cyc < 3000) begin
      if (ign && cyc == 5) begin
        m = 4'd1;
        n = 4'd1;
        k = 4'd1;
        start = 1'b1;
      end
      if (ign && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    if (zero) chk({tag, "_lat_le2"}, 64'(cyc <= 2), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, 64'(wr_cnt), 64'(exp_wr));
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic set_t1();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = (r == c) ? 1 : 0;
        bmat[r][c] = r * 4 + c + 1;
      end
  endtask

  task automatic set_rand();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = int'($urandom_range(0, 255));
        bmat[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  initial begin
    int cyc;
    fork
      monitor();
    join_none
    for (int i = 0; i < 256; i++) begin
      amem[i] = '0;
      bmem[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(o_wr_en), 64'd0);
    chk("rst_a_index", 64'(a_index), 64'd0);
    chk("rst_b_index", 64'(b_index), 64'd0);
    chk("rst_o_index", 64'(o_index), 64'd0);
    chk("rst_o_wdata", 64'(o_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    set_rand();
    run("t5_k0", 3, 3, 0, 1'b0);

    set_t1();
    run("t1", 4, 4, 4, 1'b0);
    chk("t1_word0", 64'(first_wd), 64'h01020304);

    set_rand();
    run("ign_start", 4, 4, 4, 1'b1);

    set_rand();
    run("t2", 2, 2, 2, 1'b0);

    set_rand();
    run("t3", 9, 9, 9, 1'b0);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = 255;
        bmat[r][c] = 255;
      end
    run("t4", 4, 4, 4, 1'b0);
    chk("t4_word0", 64'(first_wd), 64'h04040404);

    set_rand();
    run("mixed", 7, 10, 5, 1'b0);

    set_rand();
    prep("t6", 8, 8, 8);
    kick(8, 8, 8);
    cyc = 0;
    while (wr_cnt < 4 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_tile1_wr", 64'(wr_cnt), 64'd4);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_wr_en", 64'(o_wr_en), 64'd0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_post_wr_en", 64'(o_wr_en), 64'd0);
    chk("t6_post_a_index", 64'(a_index), 64'd0);

    set_t1();
    run("t6_restart", 4, 4, 4, 1'b0);
    chk("t6_word0", 64'(first_wd), 64'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
